// File: rtl/mem_arbiter.sv
// mem_arbiter: two-to-one block arbiter sharing one slow-memory port between I-cache and D-cache.
// Ports:
//   clk, rst_n                                 clock, synchronous active-low reset
//   i_read/i_write/i_addr/i_wdata              I-cache block request
//   i_rdata/i_ready                            I-cache read data (broadcast) and completion pulse
//   d_read/d_write/d_addr/d_wdata              D-cache block request
//   d_rdata/d_ready                            D-cache read data (broadcast) and completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata      request to slow memory (registered only)
//   mem_rdata/mem_ready                        response from slow memory
module mem_arbiter #(
    parameter int ROUND_ROBIN  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_read,
    input  logic         i_write,
    input  logic [27:0]  i_addr,
    input  logic [127:0] i_wdata,
    output logic [127:0] i_rdata,
    output logic         i_ready,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [27:0]  d_addr,
    input  logic [127:0] d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t         r_state;
    state_t         w_next;
    logic           r_last_d;
    logic [3:0]     r_starve;
    logic           r_op_read;
    logic           r_op_write;
    logic [27:0]    r_addr;
    logic [127:0]   r_wdata;

    logic w_i_req;
    logic w_d_req;
    logic w_start;
    logic w_grant_d;
    logic w_sel_read;
    logic w_sel_write;

    assign w_i_req = i_read | i_write;
    assign w_d_req = d_read | d_write;
    assign w_start = (r_state == IDLE) && (w_i_req || w_d_req);
    // On a tie: round robin favours the port not granted last; fixed priority
    // favours D until I has waited through LIM consecutive D grants.
    assign w_grant_d = (w_i_req && w_d_req)
                     ? ((ROUND_ROBIN != 0) ? !r_last_d : (r_starve != LIM))
                     : w_d_req;
    assign w_sel_read  = w_grant_d ? d_read  : i_read;
    assign w_sel_write = w_grant_d ? d_write : i_write;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = w_start ? (w_grant_d ? BUSY_D : BUSY_I) : IDLE;
        else if (mem_ready)
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_d   <= 1'b0;
            r_starve   <= '0;
            r_op_read  <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_last_d   <= w_grant_d;
                r_op_write <= w_sel_write;
                r_op_read  <= w_sel_read & ~w_sel_write;
                r_addr     <= w_grant_d ? d_addr : i_addr;
                r_wdata    <= w_grant_d ? d_wdata : i_wdata;
            end
            // A requesting I implies w_start, so the else arm is exactly a D grant over a waiting I.
            if (r_state == IDLE) begin
                if (!w_i_req || !w_grant_d)
                    r_starve <= '0;
                else if (r_starve != LIM)
                    r_starve <= r_starve + 4'd1;
            end
        end
    end

    assign mem_read  = (r_state != IDLE) & r_op_read;
    assign mem_write = (r_state != IDLE) & r_op_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_ready   = (r_state == BUSY_I) & mem_ready;
    assign d_ready   = (r_state == BUSY_D) & mem_ready;
endmodule
